// File: rtl/div_sched_pkg.sv
// Shared definitions for the two-requester divider scheduler.
package div_sched_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Scheduler FSM encoding; only these three states are reachable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
    import div_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // The partial remainder is always below the divisor, so trial < 2*divisor:
    // a set top bit of diff can only mean a borrow (divisor did not fit).
    always_comb begin
        trial    = {rem, bit_in};
        diff     = trial - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_sched.sv
// Two requesters share one iterative restoring divider. Round-robin grant in
// IDLE, WIDTH shift-subtract steps in RUN, result held in DONE until taken.
//
// Handshakes: a reqN transfer happens on a rising edge with reqN_valid and
// reqN_ready both high; a response transfer happens on a rising edge with
// rsp_valid and rsp_ready both high. Once raised, rsp_valid and the rsp_*
// payload stay unchanged until that response transfer.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_dbz,
    output state_t           state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic             rr_ptr;   // requester preferred on contention (not served last)
    logic [CW-1:0]    cnt;      // remaining shift-subtract steps
    logic [WIDTH-1:0] quo;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] rem;
    logic             op_id;
    logic             op_dbz;

    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    // Arbiter: a lone requester wins; on contention the pointer decides.
    always_comb begin
        gnt1  = req1_valid && (!req0_valid || rr_ptr);
        gnt0  = req0_valid && !gnt1;
        sel_a = gnt1 ? req1_a : req0_a;
        sel_b = gnt1 ? req1_b : req0_b;
    end

    assign req0_ready = !rst && (state == IDLE) && gnt0;
    assign req1_ready = !rst && (state == IDLE) && gnt1;
    assign state_dbg  = state;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .divisor  (div_b),
        .bit_in   (quo[WIDTH-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Scheduler FSM with operand registers and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            cnt       <= '0;
            quo       <= '0;
            div_b     <= '0;
            rem       <= '0;
            op_id     <= 1'b0;
            op_dbz    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_id  <= gnt1;
                        rr_ptr <= !gnt1;
                        quo    <= sel_a;
                        div_b  <= sel_b;
                        rem    <= '0;
                        // A zero divisor runs no steps; the empty RUN cycle
                        // keeps its result timing one cycle behind acceptance.
                        op_dbz <= (sel_b == '0);
                        cnt    <= (sel_b == '0) ? '0 : CW'(WIDTH);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        rem <= rem_next;
                        quo <= {quo[WIDTH-2:0], q_bit};
                        cnt <= cnt - CW'(1);
                    end
                    if (cnt <= CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; then wait for the consumer.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= op_id;
                        rsp_q     <= op_dbz ? '1  : quo;
                        rsp_r     <= op_dbz ? quo : rem;
                        rsp_dbz   <= op_dbz;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: reset values, latency, round-robin grant,
// divide-by-zero, output stall, reset abort and a table of operand pairs.
module tb_div_sched;
    import div_sched_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_q;
    logic [W-1:0] rsp_r;
    logic         rsp_dbz;
    state_t       state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];

    div_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_q      (rsp_q),
        .rsp_r      (rsp_r),
        .rsp_dbz    (rsp_dbz),
        .state_dbg  (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
    endtask

    // Wait (bounded) for requester id to be granted, let the edge take it, drop valid.
    task automatic wait_accept(input int id, input string tag);
        int n = 0;
        @(negedge clk);
        while (((id == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_grant"}, {31'd0, (id == 0) ? req0_ready : req1_ready}, 32'd1);
        chk({tag, "_other"}, {31'd0, (id == 0) ? req1_ready : req0_ready}, 32'd0);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Called at #1 after the accept edge: measure latency, check payload, consume.
    task automatic collect(input string tag, input logic exp_id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic exp_dbz, input int exp_lat);
        int cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, exp_id});
        chk({tag, "_q"}, {16'd0, rsp_q}, {16'd0, eq});
        chk({tag, "_r"}, {16'd0, rsp_r}, {16'd0, er});
        chk({tag, "_dbz"}, {31'd0, rsp_dbz}, {31'd0, exp_dbz});
        if (b != '0) begin
            chk({tag, "_ident"}, 32'(rsp_q) * 32'(b) + 32'(rsp_r), 32'(a));
            chk({tag, "_rltb"}, {31'd0, rsp_r < b}, 32'd1);
        end
        chk({tag, "_nobypass"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_idle"}, {30'd0, state_dbg}, {30'd0, IDLE});
    endtask

    logic [W-1:0] ta [12];
    logic [W-1:0] tb [12];

    initial begin
        logic [2*W-1:0] e;
        int cyc;
        int seen;

        // reset values with both requesters asserting
        drive(0, 16'd5, 16'd1);
        drive(1, 16'd6, 16'd2);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_q", {16'd0, rsp_q}, 32'd0);
        chk("rst_r", {16'd0, rsp_r}, 32'd0);
        chk("rst_dbz", {31'd0, rsp_dbz}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});

        // contention straight out of reset: req0 first, then req1
        drive(0, 16'd16, 16'd3);
        drive(1, 16'd255, 16'd5);
        rst = 1'b0;
        wait_accept(0, "rr_a");
        collect("rr_a", 1'b0, 16'd16, 16'd3, 16'd5, 16'd1, 1'b0, 17);
        wait_accept(1, "rr_b");
        collect("rr_b", 1'b1, 16'd255, 16'd5, 16'd51, 16'd0, 1'b0, 17);

        // lone req0 (100,10)
        drive(0, 16'd100, 16'd10);
        wait_accept(0, "lone");
        collect("lone", 1'b0, 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, 17);

        // both valid again after serving req0: req1 granted first
        drive(0, 16'd16, 16'd3);
        drive(1, 16'd255, 16'd5);
        wait_accept(1, "rr_c");
        collect("rr_c", 1'b1, 16'd255, 16'd5, 16'd51, 16'd0, 1'b0, 17);
        wait_accept(0, "rr_d");
        collect("rr_d", 1'b0, 16'd16, 16'd3, 16'd5, 16'd1, 1'b0, 17);

        // divide by zero on req1
        drive(1, 16'd70, 16'd0);
        wait_accept(1, "dbz");
        collect("dbz", 1'b1, 16'd70, 16'd0, 16'hFFFF, 16'd70, 1'b1, 2);

        // stalled consumer: payload stable, no grant while holding
        drive(0, 16'd200, 16'd40);
        wait_accept(0, "stall");
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("stall_lat", cyc, 17);
        drive(0, 16'd7, 16'd7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_q", {16'd0, rsp_q}, 32'd5);
            chk("stall_r", {16'd0, rsp_r}, 32'd0);
            chk("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("stall_drop", {31'd0, rsp_valid}, 32'd0);
        chk("stall_idle", {30'd0, state_dbg}, {30'd0, IDLE});
        chk("stall_regrant", {31'd0, req0_ready}, 32'd1);
        req0_valid = 1'b0;   // withdrawn before any edge: must not be queued
        repeat (3) @(posedge clk);
        #1;
        chk("noqueue_valid", {31'd0, rsp_valid}, 32'd0);
        chk("noqueue_idle", {30'd0, state_dbg}, {30'd0, IDLE});

        // reset in the middle of RUN aborts the operation
        drive(0, 16'd90, 16'd9);
        wait_accept(0, "abort");
        repeat (5) @(posedge clk);
        #1;
        drive(0, 16'd1, 16'd1);
        drive(1, 16'd2, 16'd1);
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_q", {16'd0, rsp_q}, 32'd0);
        chk("abort_r", {16'd0, rsp_r}, 32'd0);
        chk("abort_id_dbz", {30'd0, rsp_id, rsp_dbz}, 32'd0);
        chk("abort_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("abort_state", {30'd0, state_dbg}, {30'd0, IDLE});
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        drive(1, 16'd90, 16'd9);
        wait_accept(1, "after_rst");
        collect("after_rst", 1'b1, 16'd90, 16'd9, 16'd10, 16'd0, 1'b0, 17);

        // operand table: edge pairs, then random pairs
        ta[0] = 16'd5;     tb[0] = 16'd9;
        ta[1] = 16'd1234;  tb[1] = 16'd1;
        ta[2] = 16'd0;     tb[2] = 16'd77;
        ta[3] = 16'hFFFF;  tb[3] = 16'hFFFF;
        ta[4] = 16'hFFFF;  tb[4] = 16'd1;
        ta[5] = 16'd1;     tb[5] = 16'hFFFF;
        ta[6] = 16'd40000; tb[6] = 16'd3;
        ta[7] = 16'hFFFE;  tb[7] = 16'h8000;
        for (int i = 8; i < 12; i++) begin
            ta[i] = W'($urandom_range(0, 65535));
            tb[i] = W'($urandom_range(1, 65535));
        end
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({ta[i] / tb[i], ta[i] % tb[i]});
            drive(i % 2, ta[i], tb[i]);
            wait_accept(i % 2, "tbl");
            e = exp_q.pop_front();
            collect("tbl", 1'((i % 2) != 0), ta[i], tb[i], e[2*W-1:W], e[W-1:0], 1'b0, 17);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
